chunked_seq_adder: RTL and testbench

- Parametrised multi-cycle carry-propagate adder/subtractor; successor to the team's fixed 8-bit combinational ripple-carry adder.
- Adds one CHUNK-bit slice per clock, LSB slice first.
- The carry is held in a register between slices. This trades latency for a short critical path.
- Start/done handshake, add or subtract mode, unsigned carry-out and signed overflow flags.

---
 rtl/chunked_seq_adder.sv | 106 ++++++++++
 tb/tb_chunked_seq_adder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB slice first,
// with the inter-slice carry held in a register to keep the critical path short.
module chunked_seq_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, sum_q;
   logic             carry_q, cout_q, ovf_q, busy_q, done_q;
   logic [IDXW-1:0]  idx_q;

   logic [CHUNK-1:0] slice_a, slice_b, slice_s;
   logic             slice_c, msb_cin;
   int               slice_base;

   always_comb begin
      slice_base = int'(idx_q) * CHUNK;
      slice_a    = a_q[slice_base +: CHUNK];
      slice_b    = b_q[slice_base +: CHUNK];
      {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};
      // Carry into the top bit of the slice, recovered from that bit's sum.
      msb_cin    = slice_a[CHUNK-1] ^ slice_b[CHUNK-1] ^ slice_s[CHUNK-1];
      acc_d      = acc_q;
      acc_d[slice_base +: CHUNK] = slice_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  // Subtraction folds into addition: a + ~b + (1 - cin).
                  a_q     <= a;
                  b_q     <= b ^ {WIDTH{sub}};
                  carry_q <= cin ^ sub;
                  idx_q   <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               acc_q   <= acc_d;
               carry_q <= slice_c;
               idx_q   <= idx_q + IDXW'(1);
               if (idx_q == IDXW'(N - 1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  sum_q   <= acc_d;
                  cout_q  <= slice_c;
                  ovf_q   <= msb_cin ^ slice_c;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Scoreboard bench: a 16/4 instance for directed and protocol cases, plus 4/2 and
// 4/1 instances swept over every {a,b,cin,sub} against an integer model.
module tb_chunked_seq_adder;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_small_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        start = 1'b0, cin = 1'b0, sub = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        busy, done, cout, ovf;
   logic [15:0] sum;

   logic       s2_start = 1'b0, s2_cin = 1'b0, s2_sub = 1'b0;
   logic [3:0] s2_a = '0, s2_b = '0, s2_sum;
   logic       s2_busy, s2_done, s2_cout, s2_ovf;

   logic       s1_start = 1'b0, s1_cin = 1'b0, s1_sub = 1'b0;
   logic [3:0] s1_a = '0, s1_b = '0, s1_sum;
   logic       s1_busy, s1_done, s1_cout, s1_ovf;

   chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(ovf));

   chunked_seq_adder #(.WIDTH(4), .CHUNK(2)) dut2 (
      .clk(clk), .rst_n(rst_small_n), .start(s2_start), .a(s2_a), .b(s2_b), .cin(s2_cin),
      .sub(s2_sub), .busy(s2_busy), .done(s2_done), .sum(s2_sum), .cout(s2_cout),
      .overflow(s2_ovf));

   chunked_seq_adder #(.WIDTH(4), .CHUNK(1)) dut1 (
      .clk(clk), .rst_n(rst_small_n), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin),
      .sub(s1_sub), .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout),
      .overflow(s1_ovf));

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t       q[$];
   logic [5:0] q2[$];
   logic [5:0] q1[$];
   int         tests = 0;
   int         fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Whole-word integer model: {sum[3:0], cout, overflow}.
   function automatic logic [5:0] model4(input int av, input int bv, input int ci, input int sb);
      int ua, ub, sa, sbv, tot, stot;
      logic [3:0] s;
      logic c, o;
      ua  = av & 15;
      ub  = bv & 15;
      sa  = (ua > 7) ? ua - 16 : ua;
      sbv = (ub > 7) ? ub - 16 : ub;
      if (sb != 0) begin
         tot  = ua - ub - ci;
         stot = sa - sbv - ci;
         c    = (tot >= 0);
      end else begin
         tot  = ua + ub + ci;
         stot = sa + sbv + ci;
         c    = (tot >= 16);
      end
      s = 4'(tot & 15);
      o = (stot > 7) || (stot < -8);
      return {s, c, o};
   endfunction

   // Main-instance monitor.
   logic prev_done = 1'b0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_done) check("done_pulse_width", {31'b0, done}, 32'd0);
         if (done) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1 at cycle %0d expected no result", cyc);
            end else begin
               mon_e = q.pop_front();
               check("sum", {16'b0, sum}, {16'b0, mon_e.sum});
               check("cout", {31'b0, cout}, {31'b0, mon_e.cout});
               check("overflow", {31'b0, ovf}, {31'b0, mon_e.ovf});
               check("latency", cyc, mon_e.cyc);
            end
         end
      end
      prev_done <= done & rst_n;
   end

   always @(negedge clk) begin
      if (s2_done) begin
         if (q2.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL w4c2_unexpected_done: got done=1 expected no result");
         end else check("w4c2_result", {26'b0, s2_sum, s2_cout, s2_ovf}, {26'b0, q2.pop_front()});
      end
      if (s1_done) begin
         if (q1.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL w4c1_unexpected_done: got done=1 expected no result");
         end else check("w4c1_result", {26'b0, s1_sum, s1_cout, s1_ovf}, {26'b0, q1.pop_front()});
      end
   end

   task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic sb, input logic [15:0] es, input logic ec, input logic eo);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      a = av;
      b = bv;
      cin = ci;
      sub = sb;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.sum = es;
      e.cout = ec;
      e.ovf = eo;
      e.cyc = cyc + N;
      q.push_back(e);
   endtask

   task automatic wait_done(output bit got, output int busy_cnt);
      got = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) got = 1'b1;
      end
      check("done_seen", {31'b0, got}, 32'd1);
   endtask

   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic sb, input logic [15:0] es, input logic ec, input logic eo);
      bit got;
      int bc;
      issue(av, bv, ci, sb, es, ec, eo);
      wait_done(got, bc);
      check("busy_cycles", bc, N);
   endtask

   task automatic sweep2();
      bit got;
      for (int v = 0; v < 1024; v++) begin
         @(negedge clk);
         {s2_a, s2_b, s2_cin, s2_sub} = v[9:0];
         s2_start = 1'b1;
         @(posedge clk);
         #1;
         s2_start = 1'b0;
         q2.push_back(model4(v >> 6, v >> 2, (v >> 1) & 1, v & 1));
         got = 1'b0;
         for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (s2_done) got = 1'b1;
         end
         if (!got) check("w4c2_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic sweep1();
      bit got;
      for (int v = 0; v < 1024; v++) begin
         @(negedge clk);
         {s1_a, s1_b, s1_cin, s1_sub} = v[9:0];
         s1_start = 1'b1;
         @(posedge clk);
         #1;
         s1_start = 1'b0;
         q1.push_back(model4(v >> 6, v >> 2, (v >> 1) & 1, v & 1));
         got = 1'b0;
         for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (s1_done) got = 1'b1;
         end
         if (!got) check("w4c1_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic main_seq();
      bit got;
      int bc, k;
      exp_t e;
      #22;
      check("reset_sum", {16'b0, sum}, 32'd0);
      check("reset_flags", {28'b0, busy, done, cout, ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op(16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0);
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op(16'h0009, 16'h0004, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b0);

      // Mid-CALC start and operand changes must not disturb the operation in flight.
      issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      a = 16'hFFFF;
      b = 16'h0F0F;
      cin = 1'b1;
      sub = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(got, bc);
      repeat (8) @(negedge clk);
      check("single_done_queue", q.size(), 32'd0);

      // start held high: one result every N+2 cycles.
      @(negedge clk);
      start = 1'b1;
      a = 16'h0001;
      b = 16'h0002;
      cin = 1'b0;
      sub = 1'b0;
      @(posedge clk);
      #1;
      k = cyc;
      for (int j = 0; j < 3; j++) begin
         e.sum = 16'h0003;
         e.cout = 1'b0;
         e.ovf = 1'b0;
         e.cyc = k + N + j * (N + 2);
         q.push_back(e);
      end
      while (cyc < k + 13) @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("back_to_back_queue", q.size(), 32'd0);

      // Asynchronous reset during CALC discards the operation.
      run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
      issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_sum", {16'b0, sum}, 32'd0);
      check("async_reset_flags", {28'b0, busy, done, cout, ovf}, 32'd0);
      q.delete();
      @(negedge clk);
      check("held_reset_sum", {16'b0, sum}, 32'd0);
      rst_n = 1'b1;
      run_op(16'h4321, 16'h1234, 1'b0, 1'b1, 16'h30ED, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      check("main_queue_empty", q.size(), 32'd0);
   endtask

   initial begin
      @(negedge clk);
      rst_small_n = 1'b1;
      fork
         main_seq();
         sweep2();
         sweep1();
      join
      repeat (4) @(negedge clk);
      check("w4c2_queue_empty", q2.size(), 32'd0);
      check("w4c1_queue_empty", q1.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
